// File: rtl/iob_fifo2axis.sv
// -----------------------------------------------------------------------------
// iob_fifo2axis
//
// Bridges a synchronous FIFO read port (read data valid one cycle after the
// read strobe) to an AXI-Stream master. Up to two words are held in a small
// ordered skid buffer. Reads are only issued when the words already buffered,
// plus the one in flight, minus the one leaving this cycle, leave room. This
// gives one word per cycle when the sink is always ready, and it never
// overflows under backpressure.
//
// Optional feature (compile-time macro IOB_FIFO2AXIS_TLAST_EN):
//   defined   -> a word counter drives axis_tlast on every len-th word
//                (len = 0 means an unbounded stream with no tlast).
//   undefined -> no counter, axis_tlast tied low, len ignored.
//
// Parameters
//   DATA_W      FIFO read-data / stream data width
//   AXIS_LEN_W  width of len and of the word counter
//
// Ports
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   en           allows new FIFO reads (buffered words still drain)
//   len          packet length in words, 0 = unbounded
//   fifo_read    FIFO read enable
//   fifo_rdata   FIFO read data, valid the cycle after fifo_read
//   fifo_empty   FIFO empty flag
//   axis_tdata   stream data (buffer head)
//   axis_tvalid  stream valid
//   axis_tready  stream ready
//   axis_tlast   last word of packet
// -----------------------------------------------------------------------------
module iob_fifo2axis #(
   parameter int DATA_W     = 32,
   parameter int AXIS_LEN_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [AXIS_LEN_W-1:0] len,
   output logic                  fifo_read,
   input  logic [DATA_W-1:0]     fifo_rdata,
   input  logic                  fifo_empty,
   output logic [DATA_W-1:0]     axis_tdata,
   output logic                  axis_tvalid,
   input  logic                  axis_tready,
   output logic                  axis_tlast
);

   // two-entry ordered buffer; r_head points at the oldest word
   logic [DATA_W-1:0] r_buf [0:1];
   logic              r_head;
   logic [1:0]        r_occ;
   logic              r_pend;

   logic              w_pop;
   logic [2:0]        w_occ_next;
   logic              w_tail;

   assign w_pop = axis_tvalid & axis_tready;

   // A pop always implies occ >= 1, so this sum never goes negative.
   assign w_occ_next = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};

   // Reads are blocked during reset so nothing is fetched into a buffer
   // that is being cleared.
   assign fifo_read = ~rst & en & ~fifo_empty & (w_occ_next < 3'd2);

   assign axis_tvalid = ~rst & (r_occ != 2'd0);
   assign axis_tdata  = r_buf[r_head];

   // Slot for the arriving word. When pend=1, occ is at most 1: the read
   // was only issued if occ + pend - pop stayed below 2. The slot is the one
   // after the head when a word is already buffered. The head pointer only
   // moves at the clock edge, so a same-cycle pop at occ=1 does not disturb
   // this index.
   assign w_tail = r_head ^ r_occ[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_buf[0] <= '0;
         r_buf[1] <= '0;
         r_head   <= 1'b0;
         r_occ    <= 2'd0;
         r_pend   <= 1'b0;
      end else begin
         r_pend <= fifo_read;
         r_occ  <= w_occ_next[1:0];
         if (r_pend) begin
            r_buf[w_tail] <= fifo_rdata;
         end
         if (w_pop) begin
            r_head <= ~r_head;
         end
      end
   end

`ifdef IOB_FIFO2AXIS_TLAST_EN
   logic [AXIS_LEN_W-1:0] r_cnt;
   logic [AXIS_LEN_W-1:0] w_len_m1;
   logic                  w_at_last;

   assign w_len_m1  = len - {{(AXIS_LEN_W-1){1'b0}}, 1'b1};
   assign w_at_last = (len != '0) & (r_cnt == w_len_m1);
   assign axis_tlast = axis_tvalid & w_at_last;

   // Counts delivered words. It wraps after the tlast word. With len=0 it
   // just rolls over harmlessly, because tlast is suppressed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_pop) begin
         if (axis_tlast) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + {{(AXIS_LEN_W-1){1'b0}}, 1'b1};
         end
      end
   end
`else
   logic w_unused_len;

   assign w_unused_len = ^len;
   assign axis_tlast   = 1'b0;
`endif

endmodule

// File: tb/tb_iob_fifo2axis.sv
module tb_iob_fifo2axis;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] len;
   logic        fifo_read;
   logic [31:0] fifo_rdata;
   logic        fifo_empty;
   logic [31:0] axis_tdata;
   logic        axis_tvalid;
   logic        axis_tready;
   logic        axis_tlast;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   iob_fifo2axis #(.DATA_W(32), .AXIS_LEN_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .len        (len),
      .fifo_read  (fifo_read),
      .fifo_rdata (fifo_rdata),
      .fifo_empty (fifo_empty),
      .axis_tdata (axis_tdata),
      .axis_tvalid(axis_tvalid),
      .axis_tready(axis_tready),
      .axis_tlast (axis_tlast)
   );

   // upstream FIFO model: wp owned by stimulus, rp by the read process
   logic [31:0] mem [0:255];
   int wp = 0;
   int rp = 0;
   assign fifo_empty = (wp == rp);

   always @(posedge clk) begin
      if (fifo_read) begin
         fifo_rdata <= mem[rp % 256];
         rp         <= rp + 1;
      end
   end

   // output monitor and read-while-empty watchdog
   logic [31:0] outd [0:255];
   logic        outl [0:255];
   int          outc [0:255];
   int          n_out = 0;
   int          cyc   = 0;
   int          viol  = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_read && fifo_empty) viol <= viol + 1;
      if (axis_tvalid && axis_tready && !rst) begin
         outd[n_out % 256] <= axis_tdata;
         outl[n_out % 256] <= axis_tlast;
         outc[n_out % 256] <= cyc;
         n_out             <= n_out + 1;
      end
   end

   task automatic push(input logic [31:0] d);
      mem[wp % 256] = d;
      wp = wp + 1;
   endtask

   task automatic pulse_reset;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      int base;
      rst = 1'b1; en = 1'b1; axis_tready = 1'b0; len = '0;
      push(32'hA1); push(32'hA2); push(32'hA3);
      repeat (3) @(negedge clk);
      total++; if (fifo_read !== 1'b0) begin bad++; $display("FAIL rst_fifo_read got=%b exp=0", fifo_read); end
      total++; if (axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b exp=0", axis_tvalid); end
      total++; if (axis_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%b exp=0", axis_tlast); end
      base = n_out;
      rst = 1'b0;
      #1;
      total++; if (fifo_read !== 1'b1) begin bad++; $display("FAIL rel_c1_fifo_read got=%b exp=1", fifo_read); end
      @(negedge clk);
      total++; if (axis_tvalid !== 1'b0) begin bad++; $display("FAIL rel_c2_tvalid got=%b exp=0", axis_tvalid); end
      @(negedge clk);
      total++; if (axis_tvalid !== 1'b1 || axis_tdata !== 32'hA1) begin bad++; $display("FAIL rel_c3_first got=%b/%h exp=1/a1", axis_tvalid, axis_tdata); end
      @(negedge clk);
      total++; if (axis_tdata !== 32'hA1 || fifo_read !== 1'b0) begin bad++; $display("FAIL rel_full_hold got=%h/%b exp=a1/0", axis_tdata, fifo_read); end
      axis_tready = 1'b1;
      for (int k = 0; k < 40 && n_out < base + 3; k++) @(negedge clk);
      total++; if (n_out !== base + 3) begin bad++; $display("FAIL rel_count got=%0d exp=%0d", n_out - base, 3); end
      for (int i = 0; i < 3; i++) begin
         total++; if (outd[(base+i)%256] !== 32'hA1 + i) begin bad++; $display("FAIL rel_data[%0d] got=%h exp=%h", i, outd[(base+i)%256], 32'hA1 + i); end
      end
   endtask

   task automatic test_stream;
      int base;
      en = 1'b0; axis_tready = 1'b1;
      for (int i = 1; i <= 8; i++) push(i);
      @(negedge clk);
      base = n_out;
      en = 1'b1;
      for (int k = 0; k < 40 && n_out < base + 8; k++) @(negedge clk);
      total++; if (n_out !== base + 8) begin bad++; $display("FAIL stream_count got=%0d exp=8", n_out - base); end
      for (int i = 0; i < 8; i++) begin
         total++; if (outd[(base+i)%256] !== i + 1) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, outd[(base+i)%256], i + 1); end
         total++; if (outc[(base+i)%256] !== outc[base%256] + i) begin bad++; $display("FAIL stream_gap[%0d] got=%0d exp=%0d", i, outc[(base+i)%256], outc[base%256] + i); end
      end
   endtask

   task automatic test_backpressure;
      int base, kk;
      logic pv, pr;
      logic [31:0] pd;
      base = n_out;
      pv = 1'b0; pr = 1'b1; pd = '0;
      en = 1'b1;
      for (int i = 0; i < 16; i++) push(32'h100 + i);
      kk = 0;
      while (kk < 200 && n_out < base + 16) begin
         @(negedge clk);
         if (pv && !pr) begin
            total++;
            if (axis_tvalid !== 1'b1 || axis_tdata !== pd) begin
               bad++; $display("FAIL bp_stable got=%b/%h exp=1/%h", axis_tvalid, axis_tdata, pd);
            end
         end
         axis_tready = (kk % 4 == 0) || (kk % 4 == 3);
         pv = axis_tvalid; pd = axis_tdata; pr = axis_tready;
         kk++;
      end
      total++; if (n_out !== base + 16) begin bad++; $display("FAIL bp_count got=%0d exp=16", n_out - base); end
      for (int i = 0; i < 16; i++) begin
         total++; if (outd[(base+i)%256] !== 32'h100 + i) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, outd[(base+i)%256], 32'h100 + i); end
      end
      axis_tready = 1'b1;
      repeat (4) @(negedge clk);
      total++; if (n_out !== base + 16) begin bad++; $display("FAIL bp_no_dup got=%0d exp=16", n_out - base); end
   endtask

   task automatic test_empty_edge;
      int base, v0;
      base = n_out; v0 = viol;
      en = 1'b1; axis_tready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         push(32'h200 + i);
         repeat (3) @(negedge clk);
      end
      for (int k = 0; k < 20 && n_out < base + 6; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      total++; if (n_out !== base + 6) begin bad++; $display("FAIL empty_count got=%0d exp=6", n_out - base); end
      for (int i = 0; i < 6; i++) begin
         total++; if (outd[(base+i)%256] !== 32'h200 + i) begin bad++; $display("FAIL empty_data[%0d] got=%h exp=%h", i, outd[(base+i)%256], 32'h200 + i); end
      end
      total++; if (viol !== v0) begin bad++; $display("FAIL empty_read_viol got=%0d exp=0", viol - v0); end
   endtask

   task automatic test_tlast;
      int base;
      logic on, exp;
`ifdef IOB_FIFO2AXIS_TLAST_EN
      on = 1'b1;
`else
      on = 1'b0;
`endif
      pulse_reset();
      len = 16'd4; en = 1'b0; axis_tready = 1'b1;
      for (int i = 0; i < 10; i++) push(32'h300 + i);
      base = n_out;
      en = 1'b1;
      for (int k = 0; k < 40 && n_out < base + 10; k++) @(negedge clk);
      total++; if (n_out !== base + 10) begin bad++; $display("FAIL tlast_count got=%0d exp=10", n_out - base); end
      for (int i = 0; i < 10; i++) begin
         exp = on && (i == 3 || i == 7);
         total++; if (outl[(base+i)%256] !== exp) begin bad++; $display("FAIL tlast_len4[%0d] got=%b exp=%b", i, outl[(base+i)%256], exp); end
      end
      pulse_reset();
      len = 16'd0; en = 1'b0;
      for (int i = 0; i < 6; i++) push(32'h380 + i);
      base = n_out;
      en = 1'b1;
      for (int k = 0; k < 40 && n_out < base + 6; k++) @(negedge clk);
      total++; if (n_out !== base + 6) begin bad++; $display("FAIL tlast0_count got=%0d exp=6", n_out - base); end
      for (int i = 0; i < 6; i++) begin
         total++; if (outl[(base+i)%256] !== 1'b0) begin bad++; $display("FAIL tlast_len0[%0d] got=%b exp=0", i, outl[(base+i)%256]); end
      end
   endtask

   task automatic test_midreset;
      int base;
      logic on, exp;
`ifdef IOB_FIFO2AXIS_TLAST_EN
      on = 1'b1;
`else
      on = 1'b0;
`endif
      pulse_reset();
      len = 16'd4; en = 1'b1; axis_tready = 1'b1;
      base = n_out;
      for (int i = 0; i < 6; i++) push(32'h500 + i);
      for (int k = 0; k < 20 && n_out < base + 2; k++) @(negedge clk);
      axis_tready = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (n_out !== base + 2) begin bad++; $display("FAIL mid_two got=%0d exp=2", n_out - base); end
      total++; if (axis_tvalid !== 1'b1) begin bad++; $display("FAIL mid_buffered got=%b exp=1", axis_tvalid); end
      rst = 1'b1;
      #1;
      total++; if (axis_tvalid !== 1'b0 || fifo_read !== 1'b0) begin bad++; $display("FAIL mid_in_rst got=%b/%b exp=0/0", axis_tvalid, fifo_read); end
      wp = rp;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (axis_tvalid !== 1'b0) begin bad++; $display("FAIL mid_flushed got=%b exp=0", axis_tvalid); end
      base = n_out;
      for (int i = 0; i < 4; i++) push(32'h600 + i);
      axis_tready = 1'b1;
      for (int k = 0; k < 20 && n_out < base + 4; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      total++; if (n_out !== base + 4) begin bad++; $display("FAIL mid_count got=%0d exp=4", n_out - base); end
      for (int i = 0; i < 4; i++) begin
         exp = on && (i == 3);
         total++; if (outd[(base+i)%256] !== 32'h600 + i) begin bad++; $display("FAIL mid_data[%0d] got=%h exp=%h", i, outd[(base+i)%256], 32'h600 + i); end
         total++; if (outl[(base+i)%256] !== exp) begin bad++; $display("FAIL mid_tlast[%0d] got=%b exp=%b", i, outl[(base+i)%256], exp); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; en = 1'b0; len = '0; axis_tready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_empty_edge();
      test_tlast();
      test_midreset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/iob_fifo2axis.md
IOB_FIFO2AXIS -- requirements
Module: iob_fifo2axis

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: FIFO read-data and stream data width.
REQ-002 The block SHALL have parameter AXIS_LEN_W, default 16: width of the packet-length input and word counter.
REQ-003 Port clk, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port en, input, 1: enables new FIFO reads.
REQ-006 Port len, input, AXIS_LEN_W: packet length in words; 0 means unbounded (no tlast).
REQ-007 Port fifo_read, output, 1: read enable to the upstream sync FIFO r_en.
REQ-008 Port fifo_rdata, input, DATA_W: FIFO read data, valid one cycle after fifo_read.
REQ-009 Port fifo_empty, input, 1: FIFO r_empty.
REQ-010 Port axis_tdata, output, DATA_W: stream data.
REQ-011 Port axis_tvalid, output, 1: stream valid.
REQ-012 Port axis_tready, input, 1: stream ready.
REQ-013 Port axis_tlast, output, 1: last word of packet.

Function
REQ-014 Internal state SHALL be: 2-entry ordered buffer, 2-bit occupancy occ (0..2), 1-bit pend (read issued last cycle), word counter cnt (AXIS_LEN_W).
REQ-015 pop SHALL equal axis_tvalid & axis_tready.
REQ-016 fifo_read SHALL be combinational: en & ~fifo_empty & ((occ + pend - pop) < 2).
REQ-017 When pend=1, fifo_rdata SHALL be written to the buffer tail that cycle; pend_next SHALL equal fifo_read.
REQ-018 occ_next SHALL equal occ + pend - pop; overflow SHALL be impossible by REQ-016.
REQ-019 axis_tvalid SHALL equal (occ != 0); axis_tdata SHALL equal the buffer head; head SHALL advance on pop.
REQ-020 Latency: fifo_read in cycle t -> axis_tvalid high in cycle t+2 (empty buffer).
REQ-021 Sustained throughput SHALL be one word per cycle with axis_tready=1 and FIFO non-empty.
REQ-022 axis_tdata/axis_tvalid SHALL stay stable while axis_tvalid=1 and axis_tready=0.
REQ-023 en=0 SHALL stop new reads only; pending and buffered words SHALL still be delivered.
REQ-024 fifo_empty asserted SHALL never cause fifo_read=1; no words lost or duplicated.
REQ-025 Simultaneous pend write and pop with occ=2 SHALL not occur; with occ=1 both SHALL be honoured in the same cycle.

Reset
REQ-026 rst=1 SHALL clear occ, pend, cnt and buffer; axis_tvalid=0, axis_tlast=0, fifo_read=0 while rst=1.
REQ-027 Reset mid-packet SHALL discard buffered and in-flight words; next packet SHALL start at cnt=0.

Configuration
REQ-028 Macro IOB_FIFO2AXIS_TLAST_EN defined: axis_tlast = axis_tvalid & (len != 0) & (cnt == len-1); cnt increments on pop, wraps to 0 on pop with axis_tlast=1; len SHALL be held stable while a packet is in progress.
REQ-029 Macro undefined: cnt absent, axis_tlast tied 0, len ignored; all other behaviour unchanged.

Verification
REQ-030 Reset: rst=1 with FIFO holding 3 words -> fifo_read=0, axis_tvalid=0; after release, first word on axis at cycle 3 after release.
REQ-031 Streaming: FIFO preloaded 0x1..0x8, en=1, tready=1 -> 8 consecutive transfers 0x1..0x8, one per cycle, no gaps.
REQ-032 Backpressure: tready toggles 1,0,0,1... over 16 words -> output order preserved, data stable while stalled, occ never >2.
REQ-033 Empty edge: FIFO gets one word every 3 cycles -> each word appears once, fifo_read never high with fifo_empty=1.
REQ-034 TLAST_EN: len=4, 10 words -> tlast on words 4 and 8 only; with len=0 never; macro undefined -> tlast always 0.
REQ-035 Mid-op reset: rst pulse after 2 of 6 words with tready=0 -> buffer flushed, tvalid=0 next cycle, cnt restarts at 0.
